// File: rtl/vm80a_intc.sv
// Vectored interrupt controller with programmable tick timer for the vm80a_core bus.
// Channel 0 is the internal timer; higher channels are external, lower index wins.
module vm80a_intc #(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned SYS_CLOCK = 50000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter logic [15:0] BASE      = 16'hFFF0
) (
  input  logic                pin_clk,
  input  logic                pin_reset,
  input  logic [15:0]         pin_a,
  input  logic [7:0]          pin_din,
  input  logic                pin_wr_n,
  input  logic                pin_sync,
  input  logic [CHANNELS-1:0] pin_irq,
  output logic                pin_int,
  output logic                pin_sel,
  output logic [7:0]          pin_dout
);

  localparam int unsigned PRESCALE = SYS_CLOCK / TICK_HZ;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW       = CHANNELS;

  localparam logic [CW-1:0] CH0       = CW'(1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);

  localparam logic [2:0] OFF_MASK  = 3'd0;
  localparam logic [2:0] OFF_PEND  = 3'd1;
  localparam logic [2:0] OFF_MODE  = 3'd2;
  localparam logic [2:0] OFF_ISR   = 3'd3;
  localparam logic [2:0] OFF_EOI   = 3'd4;
  localparam logic [2:0] OFF_RELLO = 3'd5;
  localparam logic [2:0] OFF_RELHI = 3'd6;

  logic [CW-1:0] mask_q, mode_q, pend_q, isr_q;
  logic [CW-1:0] irq_s1, irq_s2, irq_s3;
  logic [15:0]   reload_q, cnt_q;
  logic [PW-1:0] presc_q;
  logic          wr_q;
  logic          inta_q;
  logic [7:0]    vec_q;

  logic [16:0]   rel;
  logic          hit, wr_hit, ack, tick, timer_evt, found, eoi_wr;
  logic [2:0]    off, win;
  logic [CW-1:0] din_ch, pend_view, allow, elig, win_oh, eoi_oh;
  logic [CW-1:0] pend_set, pend_clr, pend_d, isr_d;
  logic [15:0]   cnt_d;
  logic [7:0]    rd_data;

  // Address decode and single-shot write strobe on the falling edge of pin_wr_n
  always_comb begin
    rel    = {1'b0, pin_a} - {1'b0, BASE};
    hit    = (pin_a >= BASE) && (rel <= 17'd6);
    off    = rel[2:0];
    wr_hit = hit && !pin_wr_n && !wr_q;
    eoi_wr = wr_hit && (off == OFF_EOI);
    din_ch = pin_din[CW-1:0];
    ack    = pin_sync && pin_din[0];
  end

  // Level-mode channels see the synchronised pin; edge channels and the timer are latched
  always_comb begin
    pend_view = (pend_q & (mode_q | CH0)) | (irq_s2 & ~mode_q & ~CH0);
  end

  // A channel is allowed only if it outranks every in-service channel
  always_comb begin
    logic blk;
    blk   = 1'b0;
    allow = '0;
    for (int i = 0; i < int'(CW); i++) begin
      blk      = blk | isr_q[i];
      allow[i] = ~blk;
    end
    elig = pend_view & mask_q & allow;
  end

  // Winner and lowest in-service bit
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int i = 0; i < int'(CW); i++) begin
      if (elig[i] && !found) begin
        found     = 1'b1;
        win       = 3'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic seen;
    seen   = 1'b0;
    eoi_oh = '0;
    for (int i = 0; i < int'(CW); i++) begin
      if (isr_q[i] && !seen) begin
        seen      = 1'b1;
        eoi_oh[i] = 1'b1;
      end
    end
  end

  // Tick timer: RELOAD=0 parks the counter; a new RELOAD is picked up on the next wrap
  always_comb begin
    tick      = (presc_q == PRESC_TOP);
    cnt_d     = cnt_q;
    timer_evt = 1'b0;
    if (reload_q == 16'd0) begin
      cnt_d = 16'd0;
    end else if (tick) begin
      cnt_d     = (cnt_q == 16'd0) ? (reload_q - 16'd1) : (cnt_q - 16'd1);
      timer_evt = (cnt_d == 16'd0);
    end
  end

  // Pending/in-service update; a set beats a clear in the same cycle
  always_comb begin
    pend_set = (irq_s2 & ~irq_s3 & ~CH0) | (timer_evt ? CH0 : '0);
    pend_clr = '0;
    if (wr_hit && (off == OFF_PEND)) pend_clr = din_ch;
    if (ack && found)                pend_clr = pend_clr | win_oh;
    pend_clr = pend_clr & (mode_q | CH0);
    pend_d   = (pend_q & ~pend_clr) | pend_set;
    isr_d    = (isr_q & ~(eoi_wr ? eoi_oh : '0)) | ((ack && found) ? win_oh : '0);
  end

  always_comb begin
    rd_data = 8'h00;
    case (off)
      OFF_MASK:  rd_data = 8'(mask_q);
      OFF_PEND:  rd_data = 8'(pend_view);
      OFF_MODE:  rd_data = 8'(mode_q);
      OFF_ISR:   rd_data = 8'(isr_q);
      OFF_RELLO: rd_data = reload_q[7:0];
      OFF_RELHI: rd_data = reload_q[15:8];
      default:   rd_data = 8'h00;
    endcase
  end

  assign pin_sel  = inta_q | hit;
  assign pin_dout = inta_q ? vec_q : rd_data;

  always_ff @(posedge pin_clk or posedge pin_reset) begin
    if (pin_reset) begin
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      isr_q    <= '0;
      irq_s1   <= '0;
      irq_s2   <= '0;
      irq_s3   <= '0;
      reload_q <= '0;
      cnt_q    <= '0;
      presc_q  <= '0;
      wr_q     <= 1'b0;
      inta_q   <= 1'b0;
      vec_q    <= '0;
      pin_int  <= 1'b0;
    end else begin
      irq_s1  <= pin_irq;
      irq_s2  <= irq_s1;
      irq_s3  <= irq_s2;
      wr_q    <= ~pin_wr_n;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      pin_int <= |elig;
      if (wr_hit && (off == OFF_MASK))  mask_q <= din_ch;
      if (wr_hit && (off == OFF_MODE))  mode_q <= din_ch;
      if (wr_hit && (off == OFF_RELLO)) reload_q[7:0]  <= pin_din;
      if (wr_hit && (off == OFF_RELHI)) reload_q[15:8] <= pin_din;
      if (ack) begin
        inta_q <= 1'b1;
        vec_q  <= found ? (8'hC7 | {2'b00, win, 3'b000}) : 8'hFF;
      end else if (pin_sync && !pin_din[0]) begin
        inta_q <= 1'b0;
      end
    end
  end

endmodule
